// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scanner with double-buffered patterns.
// The host writes a shadow buffer; it is copied to the displayed buffer once per frame.
module seg_scan_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_pattern,
  output logic       wr_ready,
  input  logic [7:0] blank_mask,
  output logic [7:0] seg_out,
  output logic [7:0] an_out,
  output logic       frame_done
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  logic             slot_end;
  logic             commit;
  logic             wr_accept;
  logic [7:0][7:0]  active_all;
  logic [7:0]       active_sel;

  assign slot_end  = (cnt_q == CNT_MAX);
  assign commit    = slot_end && (idx_q == 3'd7) && !rst;
  // Blocking writes on the commit edge keeps the copied frame coherent.
  assign wr_ready  = !commit;
  assign wr_accept = wr_en && wr_ready && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic [7:0] shadow_q, shadow_d;
      logic [7:0] active_q, active_d;

      always_comb begin
        shadow_d = shadow_q;
        if (wr_accept && (wr_addr == 3'(gi))) begin
          shadow_d = wr_pattern;
        end
        active_d = commit ? shadow_q : active_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= 8'h00;
          active_q <= 8'h00;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
        end
      end

      assign active_all[gi] = active_q;
    end
  endgenerate

  assign active_sel = active_all[idx_q];

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end ? idx_q + 3'd1 : idx_q;
    frame_done_d = commit;
    seg_d = 8'hFF;
    an_d  = 8'hFF;
    // Anodes stay off during the blanking window so the previous digit cannot ghost.
    if (!(cnt_q < BLANK_END) && !blank_mask[idx_q]) begin
      seg_d = ~active_sel;
      an_d  = ~(8'b1 << idx_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      seg_q        <= 8'hFF;
      an_q         <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a time-based frame model.
module tb_seg_scan_driver;

  localparam int CLK_HZ = 80;
  localparam int SCAN_HZ = 10;
  localparam int BLANK = 2;
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int FRAME = 8 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_pattern = 8'h00;
  logic       wr_ready;
  logic [7:0] blank_mask = 8'h00;
  logic [7:0] seg_out;
  logic [7:0] an_out;
  logic       frame_done;

  seg_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_pattern(wr_pattern),
    .wr_ready(wr_ready), .blank_mask(blank_mask), .seg_out(seg_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: position in the frame is simply clocks elapsed since reset.
  int         tick = 0;
  logic [7:0] m_shadow[8];
  logic [7:0] m_active[8];
  logic [7:0] exp_seg, exp_an;
  logic       exp_fd;
  logic       valid = 1'b0;
  logic       fd_prev = 1'b0;
  int         frames_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, obs, exp, tick);
    end
  endtask

  task automatic model_edge();
    int  slot_pos, digit;
    bit  commit;
    if (rst) begin
      tick = 0;
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 8'h00;
        m_active[i] = 8'h00;
      end
      exp_seg = 8'hFF;
      exp_an  = 8'hFF;
      exp_fd  = 1'b0;
      valid   = 1'b1;
      return;
    end
    slot_pos = tick % DIV;
    digit    = (tick / DIV) % 8;
    commit   = ((tick % FRAME) == FRAME - 1);
    if (slot_pos < BLANK || blank_mask[digit]) begin
      exp_seg = 8'hFF;
      exp_an  = 8'hFF;
    end else begin
      exp_seg = ~m_active[digit];
      exp_an  = 8'hFF ^ (8'h01 << digit);
    end
    if (wr_en && !commit) m_shadow[wr_addr] = wr_pattern;
    if (commit) for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
    exp_fd = commit;
    tick++;
  endtask

  // One clock: check what the last edge produced, then drive inputs for the next edge.
  task automatic step(input logic r, input logic we, input logic [2:0] a,
                      input logic [7:0] p, input logic [7:0] m);
    @(negedge clk);
    if (valid) begin
      chk("seg_out", {24'd0, seg_out}, {24'd0, exp_seg});
      chk("an_out", {24'd0, an_out}, {24'd0, exp_an});
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, rst || ((tick % FRAME) != FRAME - 1)});
      chk("an_onehot", {31'd0, ($countones(~an_out) <= 1)}, 32'd1);
      chk("fd_double", {31'd0, fd_prev & frame_done}, 32'd0);
      fd_prev = frame_done;
      if (frame_done === 1'b1) frames_seen++;
    end
    rst = r;
    wr_en = we;
    wr_addr = a;
    wr_pattern = p;
    blank_mask = m;
    model_edge();
  endtask

  task automatic idle(input int n, input logic [7:0] m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'h00, m);
  endtask

  task automatic idle_until(input int pos, input logic [7:0] m);
    for (int i = 0; i < FRAME && (tick % FRAME) != pos; i++) step(1'b0, 1'b0, 3'd0, 8'h00, m);
  endtask

  initial begin
    logic [7:0] pat;
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    // Idle scan: two full frames with everything dark but anodes stepping.
    idle(2 * FRAME + 4, 8'h00);
    // Mid-frame write to digit 3; visible only after the next commit.
    idle_until(20, 8'h00);
    step(1'b0, 1'b1, 3'd3, 8'h3F, 8'h00);
    idle(2 * FRAME, 8'h00);
    // wr_en held across the commit: the write in the blocked cycle is dropped.
    idle_until(FRAME - 4, 8'h00);
    step(1'b0, 1'b1, 3'd5, 8'h06, 8'h00);
    step(1'b0, 1'b1, 3'd5, 8'h06, 8'h00);
    step(1'b0, 1'b1, 3'd5, 8'h06, 8'h00);
    step(1'b0, 1'b1, 3'd5, 8'h77, 8'h00);
    step(1'b0, 1'b1, 3'd5, 8'h06, 8'h00);
    idle(FRAME + 8, 8'h00);
    // Digit 0 fully lit but masked.
    step(1'b0, 1'b1, 3'd0, 8'hFF, 8'h00);
    idle(FRAME, 8'h00);
    idle(FRAME, 8'h01);
    // Reset in slot 6 after fresh writes: nothing is committed.
    step(1'b0, 1'b1, 3'd1, 8'h5B, 8'h00);
    idle_until(6 * DIV + 3, 8'h00);
    step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00);
    idle(FRAME + 10, 8'h00);
    // Randomized traffic with occasional resets and mask changes.
    for (int i = 0; i < 4000; i++) begin
      pat = 8'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom), pat,
           ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
    end
    idle(2, 8'h00);
    chk("frames_seen", {31'd0, (frames_seen >= 40)}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
